// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register: decodes the ID instruction, sign-extends the immediate and holds it for EXE.
// One-cycle latency; stall_in holds everything, flush/load-use/no-input insert a bubble. Optional: ID_EXE_WB_BYPASS_EN.
module id_exe_stage #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   PC_in,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard_stall,
  output logic              illegal_op,
  output logic              out_valid,
  output logic [PC_W-1:0]   PC,
  output logic              RegDst,
  output logic              ALUSrc,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic [1:0]        ALUOp,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        rd_addr,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] immd
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } ctrl_t;

  typedef struct packed {
    logic              vld;
    logic [PC_W-1:0]   pc;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] immd;
  } ex_t;

  logic [5:0]        opcode;
  ctrl_t             dec_ctrl;
  logic              dec_illegal;
  logic              uses_rt;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  ex_t               d;
  ex_t               q;
  logic              illegal_q;

  assign opcode = instr[31:26];

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R:    dec_ctrl = '{reg_dst: 1'b1, alu_src: 1'b0, alu_op: 2'b10, reg_write: 1'b1,
                            mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0};
      OP_LW:   dec_ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, alu_op: 2'b00, reg_write: 1'b1,
                            mem_read: 1'b1, mem_write: 1'b0, branch: 1'b0};
      OP_SW:   dec_ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, alu_op: 2'b00, reg_write: 1'b0,
                            mem_read: 1'b0, mem_write: 1'b1, branch: 1'b0};
      OP_BEQ:  dec_ctrl = '{reg_dst: 1'b0, alu_src: 1'b0, alu_op: 2'b01, reg_write: 1'b0,
                            mem_read: 1'b0, mem_write: 1'b0, branch: 1'b1};
      OP_ADDI: dec_ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, alu_op: 2'b00, reg_write: 1'b1,
                            mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0};
      default: dec_illegal = 1'b1;
    endcase
  end

  // Only these formats actually read rt as a source; lw/addi write it instead.
  assign uses_rt = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);

  assign hazard_stall = in_valid & q.vld & q.ctrl.mem_read & (q.rt != 5'd0) &
                        ((q.rt == instr[25:21]) | ((q.rt == instr[20:16]) & uses_rt));

`ifdef ID_EXE_WB_BYPASS_EN
  assign op1 = (wb_we && wb_addr != 5'd0 && wb_addr == instr[25:21]) ? wb_data : rf_rdata1;
  assign op2 = (wb_we && wb_addr != 5'd0 && wb_addr == instr[20:16]) ? wb_data : rf_rdata2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
  assign op1 = rf_rdata1;
  assign op2 = rf_rdata2;
`endif

  always_comb begin
    d       = '0;
    d.vld   = 1'b1;
    d.pc    = PC_in;
    d.ctrl  = dec_ctrl;
    d.rd1   = op1;
    d.rd2   = op2;
    d.rs    = instr[25:21];
    d.rt    = instr[20:16];
    d.rd    = instr[15:11];
    d.shamt = instr[10:6];
    d.funct = instr[5:0];
    d.immd  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      q         <= '0;
      illegal_q <= 1'b0;
    end else if (stall_in) begin
      illegal_q <= 1'b0;
    end else if (hazard_stall || !in_valid) begin
      q         <= '0;
      illegal_q <= 1'b0;
    end else begin
      q         <= d;
      illegal_q <= dec_illegal;
    end
  end

  assign out_valid  = q.vld;
  assign PC         = q.pc;
  assign RegDst     = q.ctrl.reg_dst;
  assign ALUSrc     = q.ctrl.alu_src;
  assign ALUOp      = q.ctrl.alu_op;
  assign RegWrite   = q.ctrl.reg_write;
  assign MemRead    = q.ctrl.mem_read;
  assign MemWrite   = q.ctrl.mem_write;
  assign Branch     = q.ctrl.branch;
  assign read_data1 = q.rd1;
  assign read_data2 = q.rd2;
  assign rs_addr    = q.rs;
  assign rt_addr    = q.rt;
  assign rd_addr    = q.rd;
  assign shamt      = q.shamt;
  assign funct      = q.funct;
  assign immd       = q.immd;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Randomized and directed bench for id_exe_stage against a table-driven reference model.
module tb_id_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [15:0] PC_in;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        stall_in, flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        hazard_stall, illegal_op, out_valid;
  logic [15:0] PC;
  logic        RegDst, ALUSrc, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic [31:0] read_data1, read_data2, immd;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic [5:0]  funct;

  int n_cmp = 0;
  int n_bad = 0;

  id_exe_stage #(.PC_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .PC_in(PC_in),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .stall_in(stall_in), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .illegal_op(illegal_op), .out_valid(out_valid), .PC(PC),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .read_data1(read_data1), .read_data2(read_data2),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .shamt(shamt),
    .funct(funct), .immd(immd)
  );

  always #5 clk = ~clk;

  // Reference EXE-side state; ctrl = {RegDst, ALUSrc, ALUOp[1:0], RegWrite, MemRead, MemWrite, Branch}
  logic        m_vld, m_ill;
  logic [7:0]  m_ctrl;
  logic [15:0] m_pc;
  logic [31:0] m_r1, m_r2, m_imm, m_instr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_decode(input logic [5:0] op);
    // {known, controls}
    case (op)
      6'h00:   return 9'b1_1_0_10_1_0_0_0;
      6'h23:   return 9'b1_0_1_00_1_1_0_0;
      6'h2B:   return 9'b1_0_1_00_0_0_1_0;
      6'h04:   return 9'b1_0_0_01_0_0_0_1;
      6'h08:   return 9'b1_0_1_00_1_0_0_0;
      default: return 9'b0_0_0_00_0_0_0_0;
    endcase
  endfunction

  function automatic logic ref_hazard(input logic iv, input logic [31:0] ins);
    logic [4:0] lrt;
    logic       reads_rt;
    lrt      = m_instr[20:16];
    reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    return iv && m_vld && m_ctrl[2] && lrt != 0 &&
           (lrt == ins[25:21] || (lrt == ins[20:16] && reads_rt));
  endfunction

  task automatic model_clear();
    m_vld = 0; m_ill = 0; m_ctrl = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_instr = 0;
  endtask

  task automatic check_all();
    check("out_valid", out_valid, m_vld);
    check("illegal_op", illegal_op, m_ill);
    check("ctrl", {RegDst, ALUSrc, ALUOp, RegWrite, MemRead, MemWrite, Branch}, m_ctrl);
    check("PC", PC, m_pc);
    check("read_data1", read_data1, m_r1);
    check("read_data2", read_data2, m_r2);
    check("fields", {rs_addr, rt_addr, rd_addr, shamt, funct}, m_instr[25:0]);
    check("immd", immd, m_imm);
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [15:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input logic st,
                      input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic       haz;
    logic [8:0] dec;
    logic [31:0] o1, o2;
    @(negedge clk);
    in_valid = iv; instr = ins; PC_in = pc; rf_rdata1 = r1; rf_rdata2 = r2;
    stall_in = st; flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    haz = ref_hazard(iv, ins);
    check("hazard_stall", hazard_stall, haz);
    o1 = r1; o2 = r2;
`ifdef ID_EXE_WB_BYPASS_EN
    if (we && wa != 0 && wa == ins[25:21]) o1 = wd;
    if (we && wa != 0 && wa == ins[20:16]) o2 = wd;
`endif
    @(posedge clk);
    if (fl) model_clear();
    else if (st) m_ill = 0;
    else if (haz || !iv) model_clear();
    else begin
      dec = ref_decode(ins[31:26]);
      m_vld = 1; m_ill = !dec[8]; m_ctrl = dec[7:0]; m_pc = pc;
      m_r1 = o1; m_r2 = o2; m_instr = ins;
      m_imm = {{16{ins[15]}}, ins[15:0]};
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [6];
    logic [31:0] w;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08;
    ops[5] = 6'($urandom_range(0, 63));
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 5)];
    w[25:21] = 5'($urandom_range(0, 5));
    w[20:16] = 5'($urandom_range(0, 5));
    return w;
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; instr = 0; PC_in = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    stall_in = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_hazard", hazard_stall, 0);
    @(negedge clk);
    rst_n = 1;

    // R-type add $3,$1,$2
    step(1, 32'h00221820, 16'h0004, 32'd5, 32'd7, 0, 0, 0, 0, 0);
    check("add_rd_addr", rd_addr, 5'd3);
    check("add_funct", funct, 6'h20);
    check("add_ctrl", {RegDst, ALUSrc, ALUOp, RegWrite}, 5'b1_0_10_1);

    // lw $4,-8($1) then dependent add $5,$4,$2: one bubble, then the add
    step(1, 32'h8C24FFF8, 16'h0008, 32'd100, 32'd0, 0, 0, 0, 0, 0);
    check("lw_immd", immd, 32'hFFFFFFF8);
    check("lw_memread", {ALUSrc, MemRead, rt_addr}, {2'b11, 5'd4});
    step(1, 32'h00822820, 16'h000C, 32'd9, 32'd2, 0, 0, 0, 0, 0);
    check("loaduse_bubble", out_valid, 0);
    step(1, 32'h00822820, 16'h000C, 32'd9, 32'd2, 0, 0, 0, 0, 0);
    check("loaduse_add", {out_valid, rd_addr}, {1'b1, 5'd5});

    // stall for three cycles holds everything, then flush beats stall
    for (int i = 0; i < 3; i++) begin
      step(1, rand_instr(), 16'($urandom), $urandom, $urandom, 1, 0, 0, 0, 0);
      check("stall_hold_pc", PC, 16'h000C);
    end
    step(1, 32'h00221820, 16'h0010, 1, 2, 1, 1, 0, 0, 0);
    check("flush_over_stall", out_valid, 0);

    // illegal opcode pulse
    step(1, 32'hFC221820, 16'h0014, 3, 4, 0, 0, 0, 0, 0);
    check("illegal_pulse", {illegal_op, out_valid, MemRead, RegWrite}, 4'b1100);
    step(1, 32'h00221820, 16'h0018, 3, 4, 0, 0, 0, 0, 0);
    check("illegal_clear", illegal_op, 0);
    step(1, 32'hFC221820, 16'h001C, 3, 4, 0, 0, 0, 0, 0);
    step(1, 32'h00221820, 16'h0020, 3, 4, 1, 0, 0, 0, 0);
    check("illegal_clear_on_stall", illegal_op, 0);

    // writeback bypass on rs
    step(1, 32'h00221820, 16'h0024, 32'h1111, 32'h2222, 0, 0, 1, 5'd1, 32'hDEAD);
`ifdef ID_EXE_WB_BYPASS_EN
    check("bypass_rs", read_data1, 32'hDEAD);
`else
    check("no_bypass_rs", read_data1, 32'h1111);
`endif

    // randomized traffic, biased toward small register numbers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, rand_instr(), 16'($urandom), $urandom, $urandom,
           $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
           1'($urandom), 5'($urandom_range(0, 5)), $urandom);
    end

    // asynchronous reset while a valid instruction sits in EXE
    step(1, 32'h00221820, 16'h0040, 5, 7, 0, 0, 0, 0, 0);
    check("pre_reset_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1;
    step(1, 32'h00221820, 16'h0044, 5, 7, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
